// File: rtl/seg7_pkg.sv
// seg7_pkg: shared glyph type, glyph constants, hex glyph lookup and the
// display driver FSM state encoding.
package seg7_pkg;

    typedef logic [7:0] seg_t;  // {dp,g,f,e,d,c,b,a}, active-high

    localparam seg_t SEG_BLANK = 8'h00;
    localparam seg_t SEG_MINUS = 8'h40;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_LATCH   = 2'd3
    } state_t;

    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        seg_t s;
        case (nib)
            4'h0: s = 8'h3F;
            4'h1: s = 8'h06;
            4'h2: s = 8'h5B;
            4'h3: s = 8'h4F;
            4'h4: s = 8'h66;
            4'h5: s = 8'h6D;
            4'h6: s = 8'h7D;
            4'h7: s = 8'h07;
            4'h8: s = 8'h7F;
            4'h9: s = 8'h6F;
            4'hA: s = 8'h77;
            4'hB: s = 8'h7C;
            4'hC: s = 8'h39;
            4'hD: s = 8'h5E;
            4'hE: s = 8'h79;
            default: s = 8'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_sr_display_driver_if.sv
// seg7_sr_display_driver_if: valid/ready input word channel of the display
// driver. The datapath side is the master, the driver is the slave.
interface seg7_sr_display_driver_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_2s_comp;
    logic                  i_valid;
    logic                  o_ready;

    modport master (output i_data, output i_2s_comp, output i_valid, input o_ready);
    modport slave  (input i_data, input i_2s_comp, input i_valid, output o_ready);
endinterface

// File: rtl/seg7_sr_display_driver_sr_serializer.sv
// sr_serializer: shifts a glyph frame MSB first onto a 74HC595-style chain.
// Each bit is presented for CLK_DIV cycles with the shift clock low, then
// CLK_DIV cycles with it high; after the last bit the latch is pulsed for
// CLK_DIV cycles and done pulses in the final latch cycle.
module sr_serializer #(
    parameter int FRAME_W = 40,
    parameter int CLK_DIV = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] frame,
    input  logic               start,
    output logic               sr_data,
    output logic               sr_clk,
    output logic               sr_latch,
    output logic               done
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

    logic [FRAME_W-1:0] shreg;
    logic [DIV_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic               shifting;
    logic               latching;
    logic               phase_hi;
    logic               div_last;
    logic               bit_last;

    assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign bit_last = (bit_cnt == BIT_W'(FRAME_W - 1));
    // Serial data is the MSB of the shift register, so it only changes when
    // a new bit phase starts (low half), never across the rising edge.
    assign sr_data  = shreg[FRAME_W-1];
    assign done     = latching && div_last;

    // Bit-phase sequencer: divider, half-period toggling, bit count, latch pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shifting <= 1'b0;
            latching <= 1'b0;
            phase_hi <= 1'b0;
            sr_clk   <= 1'b0;
            sr_latch <= 1'b0;
        end else if (shifting) begin
            if (div_last) begin
                div_cnt <= '0;
                if (!phase_hi) begin
                    phase_hi <= 1'b1;
                    sr_clk   <= 1'b1;
                end else begin
                    phase_hi <= 1'b0;
                    sr_clk   <= 1'b0;
                    if (bit_last) begin
                        // Park data low and open the latch window.
                        shreg    <= '0;
                        shifting <= 1'b0;
                        latching <= 1'b1;
                        sr_latch <= 1'b1;
                    end else begin
                        shreg   <= {shreg[FRAME_W-2:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end else if (latching) begin
            if (div_last) begin
                div_cnt  <= '0;
                latching <= 1'b0;
                sr_latch <= 1'b0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end else if (start) begin
            shreg    <= frame;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            phase_hi <= 1'b0;
            shifting <= 1'b1;
        end
    end
endmodule

// File: rtl/seg7_sr_display_driver.sv
// seg7_sr_display_driver: accepts a DATA_WIDTH word over valid/ready, turns it
// into hex 7-seg glyphs (optional two's complement sign) and streams the frame
// into an external shift-register chain via sr_serializer.
// Build option: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits
// and float the minus sign next to the most significant digit.
module seg7_sr_display_driver
    import seg7_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_DIGITS = 5,
    parameter int SEG_BITS   = 8,
    parameter int CLK_DIV    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    seg7_sr_display_driver_if.slave bus,
    output logic                    o_done,
    output logic                    o_sr_data,
    output logic                    o_sr_clk,
    output logic                    o_sr_latch
);
    localparam int FRAME_W = NUM_DIGITS * SEG_BITS;
    localparam int MAG_W   = 4 * NUM_DIGITS;

    // Room for every magnitude nibble plus the sign digit, so no overflow case.
    if (NUM_DIGITS < DATA_WIDTH / 4 + 1) begin : g_bad_digits
        $error("NUM_DIGITS too small for DATA_WIDTH plus sign");
    end
    if (DATA_WIDTH % 4 != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of 4");
    end
    if (SEG_BITS != $bits(seg_t)) begin : g_bad_seg
        $error("SEG_BITS must match the glyph width");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("CLK_DIV must be at least 1");
    end

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  tc_q;
    logic                  neg;
    logic [DATA_WIDTH:0]   mag;
    logic [MAG_W-1:0]      mag_ext;
    logic [FRAME_W-1:0]    frame;
    logic                  ser_done;

    assign bus.o_ready = (state == ST_IDLE);
    assign o_done      = (state == ST_IDLE);

    // Capture the word on the accept edge; it is held for the whole frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            tc_q   <= 1'b0;
        end else if (state == ST_IDLE && bus.i_valid) begin
            data_q <= bus.i_data;
            tc_q   <= bus.i_2s_comp;
        end
    end

    // Glyph build: magnitude one bit wider so the most negative value fits.
    always_comb begin
        seg_t glyph;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        int   msd;
`endif
        neg     = tc_q && data_q[DATA_WIDTH-1];
        mag     = neg ? ({1'b0, ~data_q} + 1'b1) : {1'b0, data_q};
        mag_ext = MAG_W'(mag);
        frame   = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        msd = 0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (mag_ext[4*k +: 4] != 4'h0) msd = k;
        end
`endif
        for (int k = 0; k < NUM_DIGITS; k++) begin
            glyph = hex_to_seg(mag_ext[4*k +: 4]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (k > msd) glyph = (neg && k == msd + 1) ? SEG_MINUS : SEG_BLANK;
`else
            if (neg && k == NUM_DIGITS - 1) glyph = SEG_MINUS;
`endif
            frame[k*SEG_BITS +: SEG_BITS] = glyph;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // FSM next state: the serializer paces SHIFT and LATCH; done may arrive
    // while still in SHIFT when the latch window is a single cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (bus.i_valid) state_nxt = ST_CONVERT;
            ST_CONVERT: state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                if (ser_done)        state_nxt = ST_IDLE;
                else if (o_sr_latch) state_nxt = ST_LATCH;
            end
            ST_LATCH:   if (ser_done) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    sr_serializer #(
        .FRAME_W (FRAME_W),
        .CLK_DIV (CLK_DIV)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .frame    (frame),
        .start    (state == ST_CONVERT),
        .sr_data  (o_sr_data),
        .sr_clk   (o_sr_clk),
        .sr_latch (o_sr_latch),
        .done     (ser_done)
    );
endmodule
